// File: rtl/gpu_net_if.sv
// gpu_net_if -- network interface stage between a GPU tile and its NoC link.
//
// TX path : GPU flits {dest[5:0], payload[9:0]} are queued in a show-ahead
//           circular FIFO. A head addressed elsewhere goes out on the link.
//           A head addressed to this node loops back into the RX slot.
// RX path : inbound link flits for other nodes are accepted and dropped.
//           Local link flits and loopback flits share one registered RX slot
//           through a round-robin arbiter.
//
// Ports
//   ACLK, ARESET                     clock, synchronous active-high reset
//   gpu_data_in/valid_in/ready_out   TX flits from the GPU
//   link_data_out/valid_out/ready_in flits to the NoC
//   link_data_in/valid_in/ready_out  flits from the NoC
//   gpu_data_out/valid_out/ready_in  RX flits to the GPU
//   tx_cnt, rx_cnt, loop_cnt, drop_cnt  saturating statistics
module gpu_net_if #(
   parameter logic [5:0] NODE_ID    = 6'd12,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [15:0] gpu_data_in,
   input  logic        gpu_valid_in,
   output logic        gpu_ready_out,
   output logic [15:0] link_data_out,
   output logic        link_valid_out,
   input  logic        link_ready_in,
   input  logic [15:0] link_data_in,
   input  logic        link_valid_in,
   output logic        link_ready_out,
   output logic [15:0] gpu_data_out,
   output logic        gpu_valid_out,
   input  logic        gpu_ready_in,
   output logic [15:0] tx_cnt,
   output logic [15:0] rx_cnt,
   output logic [15:0] loop_cnt,
   output logic [15:0] drop_cnt
);

   localparam int             PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]    DEPTH_C = (PW+1)'(FIFO_DEPTH);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      sat_inc = (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   logic [15:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;
   logic          last_grant_r;   // 1: link won the last load, 0: loopback did

   logic          empty_s;
   logic          full_s;
   logic [15:0]   head_s;
   logic          head_loop_s;
   logic          head_remote_s;
   logic          push_s;
   logic          pop_s;
   logic          link_local_s;
   logic          link_foreign_s;
   logic          rx_free_s;
   logic          grant_link_s;
   logic          grant_loop_s;

   // FIFO status, head routing and RX arbitration.
   always_comb begin
      empty_s       = (count_r == '0);
      full_s        = (count_r == DEPTH_C);
      head_s        = mem_r[rd_ptr_r];
      head_loop_s   = !empty_s && (head_s[15:10] == NODE_ID);
      head_remote_s = !empty_s && (head_s[15:10] != NODE_ID);

      link_local_s   = link_valid_in && (link_data_in[15:10] == NODE_ID);
      link_foreign_s = link_valid_in && (link_data_in[15:10] != NODE_ID);
      rx_free_s      = !gpu_valid_out || gpu_ready_in;

      // On contention the requester that did not win the last load goes first.
      grant_link_s = rx_free_s && link_local_s && (!head_loop_s || !last_grant_r);
      grant_loop_s = rx_free_s && head_loop_s && (!link_local_s || last_grant_r);

      // A pop freeing a slot in the same cycle never lets a full FIFO take a push.
      gpu_ready_out = !ARESET && !full_s;
      push_s        = gpu_valid_in && gpu_ready_out;
      pop_s         = (head_remote_s && link_ready_in) || grant_loop_s;

      link_valid_out = head_remote_s;
      link_data_out  = head_s;

      // Foreign flits are always swallowed; local ones wait for the RX slot.
      if (ARESET) begin
         link_ready_out = 1'b0;
      end else if (link_data_in[15:10] != NODE_ID) begin
         link_ready_out = 1'b1;
      end else begin
         link_ready_out = grant_link_s;
      end
   end

   // FIFO storage; contents are don't-care after reset so no reset here.
   always_ff @(posedge ACLK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= gpu_data_in;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // RX slot and arbiter history.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         gpu_valid_out <= 1'b0;
         gpu_data_out  <= 16'h0000;
         last_grant_r  <= 1'b0;
      end else if (grant_link_s) begin
         gpu_valid_out <= 1'b1;
         gpu_data_out  <= link_data_in;
         last_grant_r  <= 1'b1;
      end else if (grant_loop_s) begin
         gpu_valid_out <= 1'b1;
         gpu_data_out  <= head_s;
         last_grant_r  <= 1'b0;
      end else if (gpu_valid_out && gpu_ready_in) begin
         gpu_valid_out <= 1'b0;
      end
   end

   // Statistics.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         tx_cnt   <= 16'h0000;
         rx_cnt   <= 16'h0000;
         loop_cnt <= 16'h0000;
         drop_cnt <= 16'h0000;
      end else begin
         if (head_remote_s && link_ready_in) tx_cnt <= sat_inc(tx_cnt);
         if (grant_link_s)                   rx_cnt <= sat_inc(rx_cnt);
         if (grant_loop_s)                   loop_cnt <= sat_inc(loop_cnt);
         if (link_foreign_s)                 drop_cnt <= sat_inc(drop_cnt);
      end
   end

endmodule
